// File: rtl/l2r_pkg.sv
// Shared encodings and default width for the left-to-right exponentiation
// datapath and its control unit.
package l2r_pkg;

    // Default operand width of base, exponent and result.
    localparam int L2R_W = 8;

    // Source select for result register C.
    typedef enum logic [1:0] {
        C_ONE  = 2'b00,  // constant 1
        C_SQR  = 2'b01,  // C * C
        C_MULA = 2'b10,  // C * A
        C_RSV  = 2'b11   // reserved: C holds
    } sc_sel_e;

    // Source select for the bit counter.
    typedef enum logic {
        CNT_CLR = 1'b0,
        CNT_INC = 1'b1
    } cnt_sel_e;

endpackage

// File: rtl/l2r_mult.sv
// Combinational unsigned multiplier keeping only the low W bits of the
// full 2W-bit product (arithmetic mod 2^W).
module l2r_mult
    import l2r_pkg::*;
#(
    parameter int W = L2R_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] p
);

    logic [2*W-1:0] full_prod;

    // Full-width product, then truncate to the operand width.
    always_comb begin
        full_prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        p         = full_prod[W-1:0];
    end

endmodule

// File: rtl/l2r_datapath.sv
// Datapath for left-to-right binary exponentiation C = A^B mod 2^W.
// Holds base A, exponent shift register B, result C and a bit counter.
// It has no sequencing of its own; every cycle it obeys the control
// inputs supplied by the control unit.
module l2r_datapath
    import l2r_pkg::*;
#(
    parameter int W  = L2R_W,
    parameter int CW = $clog2(W+1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] A_in,
    input  logic [W-1:0] B_in,
    input  logic         LoadA,
    input  logic         LoadB,
    input  logic         ShiftB,
    input  logic         LoadC,
    input  logic [1:0]   S_C,
    input  logic         LoadCoun,
    input  logic         S_Coun,
    output logic         equals,
    output logic         regBk,
    output logic [W-1:0] C_out
);

    localparam logic [CW-1:0] CNT_MAX = CW'(W);

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W-1:0]  mult_y;
    logic [W-1:0]  mult_p;

    // Single shared multiplier: x is always C, y is A for the multiply
    // step and C otherwise (squaring). A is the registered value, so a
    // simultaneous LoadA never affects the product in the same cycle.
    always_comb begin
        mult_y = (sc_sel_e'(S_C) == C_MULA) ? a_q : c_q;
    end

    l2r_mult #(.W(W)) u_mult (
        .x (c_q),
        .y (mult_y),
        .p (mult_p)
    );

    // Base register: load or hold.
    always_comb begin
        a_d = a_q;
        if (LoadA) begin
            a_d = A_in;
        end
    end

    // Exponent register: load has priority over the left shift.
    always_comb begin
        b_d = b_q;
        if (LoadB) begin
            b_d = B_in;
        end else if (ShiftB) begin
            b_d = {b_q[W-2:0], 1'b0};
        end
    end

    // Result register: 1, square, or multiply by A; reserved select holds.
    always_comb begin
        c_d = c_q;
        if (LoadC) begin
            case (sc_sel_e'(S_C))
                C_ONE:   c_d = W'(1);
                C_SQR:   c_d = mult_p;
                C_MULA:  c_d = mult_p;
                default: c_d = c_q;
            endcase
        end
    end

    // Bit counter: clear, or increment saturating at W.
    always_comb begin
        cnt_d = cnt_q;
        if (LoadCoun) begin
            if (cnt_sel_e'(S_Coun) == CNT_CLR) begin
                cnt_d = '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset overrides every load, shift and count control.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
        end
    end

    // Status and result outputs are direct views of the registers.
    always_comb begin
        equals = (cnt_q == CNT_MAX);
        regBk  = b_q[W-1];
        C_out  = c_q;
    end

endmodule

// File: tb/tb_l2r_datapath.sv
// Testbench for l2r_datapath: scripted exponentiation runs plus random
// control cycles, checked against a behavioural model via an expected queue.
module tb_l2r_datapath;
  import l2r_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);
  localparam int MOD = 1 << W;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A_in, B_in;
  logic         LoadA, LoadB, ShiftB, LoadC, LoadCoun, S_Coun;
  logic [1:0]   S_C;
  logic         equals, regBk;
  logic [W-1:0] C_out;

  always #5 clk = ~clk;

  l2r_datapath #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .A_in     (A_in),
    .B_in     (B_in),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .ShiftB   (ShiftB),
    .LoadC    (LoadC),
    .S_C      (S_C),
    .LoadCoun (LoadCoun),
    .S_Coun   (S_Coun),
    .equals   (equals),
    .regBk    (regBk),
    .C_out    (C_out)
  );

  // ---------------- reference model state ----------------
  int m_a, m_b, m_c, m_cnt;

  int vectors = 0;
  int miscompares = 0;

  // expected {C_out, equals, regBk} after each applied cycle
  logic [W+1:0] exp_q[$];

  function automatic int pow_ref(input int a, input int b);
    int r;
    r = 1;
    for (int k = 0; k < b; k++) r = (r * a) % MOD;
    return r;
  endfunction

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of controls, advance the model, queue the expectation.
  task automatic cycle(input logic r, input logic la, input logic lb,
                       input logic sb, input logic lc, input logic [1:0] sc,
                       input logic lcn, input logic scn,
                       input logic [W-1:0] ain, input logic [W-1:0] bin);
    int old_a;
    rst = r; LoadA = la; LoadB = lb; ShiftB = sb; LoadC = lc; S_C = sc;
    LoadCoun = lcn; S_Coun = scn; A_in = ain; B_in = bin;
    old_a = m_a;
    if (r) begin
      m_a = 0; m_b = 0; m_c = 0; m_cnt = 0;
    end else begin
      if (la) m_a = ain;
      if (lb) m_b = bin;
      else if (sb) m_b = (m_b * 2) % MOD;
      if (lc) begin
        case (sc)
          2'd0: m_c = 1;
          2'd1: m_c = (m_c * m_c) % MOD;
          2'd2: m_c = (m_c * old_a) % MOD;
          default: ;
        endcase
      end
      if (lcn) m_cnt = scn ? ((m_cnt < W) ? m_cnt + 1 : W) : 0;
    end
    @(posedge clk);
    #1;
    exp_q.push_back({W'(m_c), (m_cnt == W), m_b >= (MOD / 2)});
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, C_ONE, 0, CNT_CLR, '0, '0);
  endtask

  // Scripted left-to-right exponentiation; abort_at >= 0 pulses reset
  // before processing that bit.
  task automatic run_pow(input int a, input int b, input int abort_at);
    logic [W-1:0] bv;
    bv = W'(b);
    cycle(0, 1, 1, 0, 1, C_ONE, 1, CNT_CLR, W'(a), bv);
    for (int i = 0; i < W; i++) begin
      if (i == abort_at) begin
        cycle(1, 1, 1, 1, 1, C_MULA, 1, CNT_INC, W'(a), bv);
        check("abort_c", int'(C_out), 0);
        check("abort_equals", int'(equals), 0);
        check("abort_regbk", int'(regBk), 0);
        return;
      end
      check("regbk_bit", int'(regBk), int'(bv[W-1-i]));
      cycle(0, 0, 0, 0, 1, C_SQR, 0, CNT_CLR, '0, '0);
      if (bv[W-1-i]) cycle(0, 0, 0, 0, 1, C_MULA, 0, CNT_CLR, '0, '0);
      cycle(0, 0, 0, 1, 0, C_ONE, 1, CNT_INC, '0, '0);
    end
    check("pow_result", int'(C_out), pow_ref(a, b));
    check("pow_equals", int'(equals), 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({C_out, equals, regBk} !== e) begin
        miscompares++;
        $display("FAIL cycle_state: got C=%0d eq=%0b bk=%0b, expected C=%0d eq=%0b bk=%0b (t=%0t)",
                 C_out, equals, regBk, e[W+1:2], e[1], e[0], $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_a = 0; m_b = 0; m_c = 0; m_cnt = 0;
    rst = 1; LoadA = 0; LoadB = 0; ShiftB = 0; LoadC = 0; S_C = 0;
    LoadCoun = 0; S_Coun = 0; A_in = '0; B_in = '0;

    // reset with every control asserted: reset must win
    cycle(1, 1, 1, 1, 1, C_ONE, 1, CNT_INC, 8'hFF, 8'hFF);
    check("reset_c", int'(C_out), 0);
    check("reset_equals", int'(equals), 0);
    check("reset_regbk", int'(regBk), 0);
    idle();

    // directed exponentiations
    run_pow(3, 5, -1);    // 243
    run_pow(3, 13, -1);   // 211, regBk 0,0,0,0,1,1,0,1
    run_pow(2, 8, -1);    // overflow -> 0
    run_pow(7, 0, -1);    // -> 1

    // reset mid-run after 4 bits, then rerun
    run_pow(3, 13, 4);
    run_pow(3, 5, -1);

    // LoadB wins over ShiftB
    cycle(0, 0, 1, 0, 0, C_ONE, 0, CNT_CLR, '0, 8'h01);
    cycle(0, 0, 1, 1, 0, C_ONE, 0, CNT_CLR, '0, 8'h80);
    check("loadb_over_shift", int'(regBk), 1);

    // counter saturation after 10 increments
    cycle(0, 0, 0, 0, 0, C_ONE, 1, CNT_CLR, '0, '0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, C_ONE, 1, CNT_INC, '0, '0);
    check("cnt_saturate_equals", int'(equals), 1);

    // simultaneous LoadA and C*A uses old A
    cycle(0, 1, 0, 0, 1, C_ONE, 0, CNT_CLR, 8'd3, '0);
    cycle(0, 1, 0, 0, 1, C_MULA, 0, CNT_CLR, 8'd5, '0);
    check("old_a_mul", int'(C_out), 3);
    cycle(0, 0, 0, 0, 1, C_MULA, 0, CNT_CLR, '0, '0);
    check("new_a_mul", int'(C_out), 15);

    // reserved select holds C
    cycle(0, 0, 0, 0, 1, C_RSV, 0, CNT_CLR, '0, '0);
    check("reserved_hold", int'(C_out), 15);

    // random full exponentiations
    for (int i = 0; i < 6; i++)
      run_pow(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)), -1);

    // random control cycles
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            W'($urandom), W'($urandom));
    end

    idle();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/l2r_datapath.md
L2R_DATAPATH -- requirements
Module: l2r_datapath

Interface
REQ-001 Parameter W, default 8: operand width of base, exponent and result.
REQ-002 Parameter CW, default $clog2(W+1): counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 A_in  in  W  base operand.
REQ-006 B_in  in  W  exponent operand.
REQ-007 LoadA  in  1  capture A_in into register A.
REQ-008 LoadB  in  1  capture B_in into register B.
REQ-009 ShiftB  in  1  shift register B left by one bit.
REQ-010 LoadC  in  1  update result register C from the S_C-selected source.
REQ-011 S_C  in  2  C source select: 00 = constant 1, 01 = C*C, 10 = C*A, 11 = reserved.
REQ-012 LoadCoun  in  1  update bit counter.
REQ-013 S_Coun  in  1  counter source: 0 = clear, 1 = increment.
REQ-014 equals  out  1  counter has reached W.
REQ-015 regBk  out  1  current exponent bit (B MSB).
REQ-016 C_out  out  W  result register C.

Function
REQ-017 A SHALL load A_in when LoadA=1; otherwise A SHALL hold.
REQ-018 When LoadB=1, B SHALL load B_in; when LoadB=0 and ShiftB=1, B SHALL become {B[W-2:0],1'b0}; otherwise B SHALL hold. LoadB SHALL win over ShiftB.
REQ-019 When LoadC=1, C SHALL take: S_C=00 -> 1; 01 -> low W bits of C*C; 10 -> low W bits of C*A, using A's value before the edge; 11 -> hold.
REQ-020 Products SHALL be unsigned, full 2W bits internally, truncated to W bits (mod 2^W). Latency is one cycle: control asserted in cycle n, result visible on C_out after edge n.
REQ-021 Counter: LoadCoun=1 with S_Coun=0 SHALL clear it to 0; with S_Coun=1 it SHALL increment, saturating at W (no wrap). LoadCoun=0 SHALL hold.
REQ-022 equals SHALL be combinational (cnt == W); regBk SHALL be combinational B[W-1]. Neither is registered.
REQ-023 Simultaneous LoadA and LoadC with S_C=10 in one cycle SHALL use the old A.
REQ-024 No internal sequencing: the block SHALL act only on the current control inputs, with no FSM of its own.

Reset
REQ-025 On a clk edge with rst=1, A=0, B=0, C=0 and cnt=0, overriding all load, shift and count controls. After reset equals=0 (W>0), regBk=0 and C_out=0.
REQ-026 rst asserted mid-exponentiation SHALL abort the operation. Subsequent operation SHALL depend only on controls applied after rst deasserts.

Structure
REQ-027 The S_C encodings (C_ONE, C_SQR, C_MULA), S_Coun encodings (CNT_CLR, CNT_INC) and default W SHALL live in shared package l2r_pkg, also used by CU.
REQ-028 The truncating multiplier SHALL be a sub-module l2r_mult (params W; inputs x, y; output p = low W bits of x*y, combinational). It SHALL be instantiated once, with its y operand muxed between C and A.

Verification (W=8, driven by CU or by a scripted control model)
REQ-029 A_in=3, B_in=5, full left-to-right sequence over 8 bits -> C_out=243 when equals=1.
REQ-030 A_in=3, B_in=13 -> C_out=211 (1594323 mod 256). Check regBk follows 0,0,0,0,1,1,0,1 across successive shifts.
REQ-031 A_in=2, B_in=8 -> C_out=0 (overflow truncation); B_in=0 -> C_out=1.
REQ-032 LoadB=1 and ShiftB=1 in the same cycle -> B=B_in, no shift. Increment counter 10 times -> cnt saturates at 8 and equals stays 1.
REQ-033 rst pulsed for one cycle mid-run (after 4 bits of B_in=13) -> C_out=0, equals=0, regBk=0 next cycle. Rerun with A_in=3, B_in=5 -> 243.
REQ-034 LoadA with A_in=5 and LoadC with S_C=10 in the same cycle, C=1, old A=3 -> C_out=3. The following C*A step -> 15.
